// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: FSM state encoding and
// stall-length constants used by the need logic and the controller.
package hazard_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned NEED_W = 2;

    // RUN: normal issue; STALL: extra bubble cycles pending for a load feeding a branch
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    localparam logic [NEED_W-1:0] STALL_NONE        = 2'd0;
    localparam logic [NEED_W-1:0] STALL_SINGLE      = 2'd1;
    localparam logic [NEED_W-1:0] STALL_LOAD_BRANCH = 2'd2;

endpackage

// File: rtl/hazard_need.sv
// Combinational hazard detector: number of stall cycles the ID instruction needs.
// Ports:
//   id_rs_i/id_rt_i, id_use_rs_i/id_use_rt_i  : ID sources and their use flags
//   id_is_branch_i                             : ID holds a branch resolved in ID
//   ex_reg_write_i, ex_mem_read_i, ex_rd_i     : EX destination control
//   mem_mem_read_i, mem_rd_i                   : MEM load destination
//   need_o                                     : 0, 1 or 2 stall cycles required
module hazard_need
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0]  id_rs_i,
    input  logic [REG_W-1:0]  id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_is_branch_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_W-1:0]  ex_rd_i,
    input  logic              mem_mem_read_i,
    input  logic [REG_W-1:0]  mem_rd_i,
    output logic [NEED_W-1:0] need_o
);

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic branch_alu;
    logic branch_mem_load;

    // $zero is never a real dependency, so a zero source never matches
    function automatic logic src_match(input logic use_f, input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst);
        return use_f && (src != '0) && (src == dst);
    endfunction

    assign ex_match  = src_match(id_use_rs_i, id_rs_i, ex_rd_i)
                     | src_match(id_use_rt_i, id_rt_i, ex_rd_i);
    assign mem_match = src_match(id_use_rs_i, id_rs_i, mem_rd_i)
                     | src_match(id_use_rt_i, id_rt_i, mem_rd_i);

    assign load_use        = ex_mem_read_i & ex_match;
    assign branch_alu      = id_is_branch_i & ex_reg_write_i & ~ex_mem_read_i & ex_match;
    assign branch_mem_load = id_is_branch_i & mem_mem_read_i & mem_match;

    // Stall length selection
    always_comb begin
        need_o = STALL_NONE;
        if (load_use && id_is_branch_i) begin
            need_o = STALL_LOAD_BRANCH;
        end else if (load_use || branch_alu || branch_mem_load) begin
            need_o = STALL_SINGLE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls ID on load-use and branch dependencies,
// flushes IF/ID on taken branches, freezes everything while data memory is busy,
// and counts bubble cycles in a saturating performance counter.
// Ports:
//   clk, Reset                      : clock, asynchronous active-high reset
//   id_*, ex_*, mem_*               : pipeline register fields used for detection
//   dmemBusy                        : data memory not ready
//   holdPC, holdIFID, bubbleIDEX    : stall controls (combinational, same cycle)
//   flushIFID                       : squash the wrong-path fetch of a taken branch
//   freezePipe                      : global freeze while memory is busy
//   stallCycles                     : saturating count of bubble cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_useRs,
    input  logic             id_useRt,
    input  logic             id_isBranch,
    input  logic             id_branchTaken,
    input  logic             ex_regWrite,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_rd,
    input  logic             mem_memRead,
    input  logic [4:0]       mem_rd,
    input  logic             dmemBusy,
    output logic             holdPC,
    output logic             holdIFID,
    output logic             bubbleIDEX,
    output logic             flushIFID,
    output logic             freezePipe,
    output logic [CNT_W-1:0] stallCycles
);

    hz_state_e         state_q, state_d;
    logic [1:0]        rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NEED_W-1:0] need;

    hazard_need u_need (
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_use_rs_i    (id_useRs),
        .id_use_rt_i    (id_useRt),
        .id_is_branch_i (id_isBranch),
        .ex_reg_write_i (ex_regWrite),
        .ex_mem_read_i  (ex_memRead),
        .ex_rd_i        (ex_rd),
        .mem_mem_read_i (mem_memRead),
        .mem_rd_i       (mem_rd),
        .need_o         (need)
    );

    // State and counter registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and Mealy outputs; the controls must act in the cycle the hazard is seen
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        holdPC     = 1'b0;
        holdIFID   = 1'b0;
        bubbleIDEX = 1'b0;
        flushIFID  = 1'b0;
        freezePipe = 1'b0;

        if (Reset) begin
            // outputs stay at their defaults while reset is applied
        end else if (dmemBusy) begin
            // freeze leaves state and rem untouched; the stall resumes afterwards
            freezePipe = 1'b1;
            holdPC     = 1'b1;
            holdIFID   = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (need != STALL_NONE) begin
                        holdPC     = 1'b1;
                        holdIFID   = 1'b1;
                        bubbleIDEX = 1'b1;
                        if (need == STALL_LOAD_BRANCH) begin
                            state_d = STALL;
                            rem_d   = STALL_LOAD_BRANCH - STALL_SINGLE;
                        end
                    end else if (id_isBranch && id_branchTaken) begin
                        flushIFID = 1'b1;
                    end
                end
                STALL: begin
                    holdPC     = 1'b1;
                    holdIFID   = 1'b1;
                    bubbleIDEX = 1'b1;
                    // rem of 0 in STALL cannot occur normally; leave rather than wrap
                    rem_d = (rem_q != 2'd0) ? (rem_q - 2'd1) : 2'd0;
                    if (rem_q <= 2'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    // Saturating bubble counter; freeze cycles never raise bubbleIDEX
    always_comb begin
        cnt_d = cnt_q;
        if (bubbleIDEX && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign stallCycles = cnt_q;

endmodule
